led_blink_scheduler: RTL
========================

Name: led_blink_scheduler

Overview:
- Shares one physical status LED between up to four requesters. Each requester asks for a burst of N blinks.
- A round-robin arbiter picks one requester at a time. A tick-counting FSM then drives the LED through timed ON/OFF phases.
- A guard gap follows each burst so that consecutive bursts stay visually distinct.
- Sits between the system-level status sources and the LED pass-through control block, which feeds o_led to the pin.

Parameters:
- N_REQ, 4, number of requesters. Legal range 2..4.
- CNT_W, 16, width of the phase tick counter.
- BLINK_W, 4, width of each requester's blink-count field.
- ON_TICKS, 25000, clock cycles the LED is lit per blink. Range 1..2^CNT_W.
- OFF_TICKS, 25000, clock cycles the LED is dark after each blink. Range 1..2^CNT_W.
- GAP_TICKS, 50000, idle cycles after each burst before the next arbitration. Range 1..2^CNT_W.

Ports:
- i_clock  in  1  system clock. All state changes on the rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req  in  N_REQ  level request per requester. Held until the matching o_ack.
- i_blinks  in  N_REQ*BLINK_W  blink count per requester. Field i = bits [i*BLINK_W +: BLINK_W]. Sampled only on grant.
- o_ack  out  N_REQ  one-cycle grant pulse to the winner.
- o_done  out  N_REQ  one-cycle pulse to the owner when its burst completes.
- o_led  out  1  LED drive, 1 = lit.
- o_busy  out  1  high whenever state != IDLE.
- o_owner  out  2  index of the current or last granted requester.

Behaviour:
- Reset (i_reset_n=0), asynchronous, effective immediately:
  - state=IDLE; o_led, o_busy, o_ack, o_done, o_owner, counters all 0.
  - Round-robin pointer = 0, so requester 0 has top priority.
  - Any in-flight burst is abandoned and no o_done is issued.
- States: IDLE, ON, OFF, GAP. All outputs are registered.
- IDLE:
  - On an edge where any i_req bit is set, grant the first set bit searching from pointer ptr, ptr+1, ... mod N_REQ.
  - After that edge: o_ack[w]=1 for one cycle, o_owner=w, ptr=w+1 mod N_REQ, remaining-blink count = i_blinks field w.
  - Nonzero count: state=ON, o_led=1, tick counter=ON_TICKS-1.
  - Zero count: o_done[w]=1 in the same cycle as o_ack[w], state=GAP, o_led stays 0.
- ON: o_led=1 for exactly ON_TICKS cycles, then OFF.
- OFF: o_led=0 for exactly OFF_TICKS cycles.
  - Each OFF decrements the remaining count.
  - If blinks remain: return to ON.
  - If none remain: state=GAP, with o_done[owner]=1 in the first GAP cycle.
- GAP: lasts exactly GAP_TICKS cycles, then IDLE. Arbitration occurs on the first edge in IDLE.
- Timing figures:
  - Minimum request-to-ack latency: 1 cycle.
  - Busy duration per burst: n*(ON_TICKS+OFF_TICKS)+GAP_TICKS cycles.
- Request handling:
  - Deassertion of i_req after ack is ignored; the burst always completes.
  - i_req held high past o_ack is treated as a new request, arbitrated after GAP.
  - Requests arriving while busy wait; none are lost while held.
- Tick counters load value-1 and count down to 0, with no overflow. The blink counter is BLINK_W wide and never wraps.

Test Plan (ON_TICKS=3, OFF_TICKS=2, GAP_TICKS=4, N_REQ=4):
1. Reset held then released with no requests → all outputs 0, o_busy=0 indefinitely.
2. i_req[0]=1 with blinks=2 → o_ack[0] 1 cycle after the sampling edge. From the ack cycle, o_led = 1,1,1,0,0,1,1,1,0,0. o_done[0] pulses on the next cycle. o_busy lasts 14 cycles.
3. i_req[0] and i_req[2] raised together, blinks=1 → requester 0 served first, then 2 after its gap. Then raise i_req[0] and i_req[1] → requester 0 wins (ptr=3 wraps to 0). Repeat → requester 1 wins.
4. i_req[3]=1 with blinks=0 → o_ack[3] and o_done[3] in the same cycle. o_led stays 0. o_busy high for 4 cycles.
5. Assert reset during the 2nd ON cycle of a blinks=3 burst for requester 2 → o_led=0 immediately, no o_done. After release with i_req[1] and i_req[3] set → requester 1 wins.
6. i_req[1] dropped one cycle after o_ack[1] with blinks=3 → 3 full blinks still emitted, o_done[1] still pulses.

Source files
------------

// File: rtl/led_blink_scheduler_if.sv
// Request/status bundle between the status sources and the blink scheduler.
// Handshake: a requester raises i_req[i] (level) with its blink count on
// i_blinks field i and holds it until it sees the one-cycle o_ack[i] pulse;
// the count is sampled only on that grant edge. o_done[i] pulses once when
// the granted burst has finished its last OFF phase (or at grant for a
// zero-length burst). Keeping i_req high past o_ack queues a new request.
interface led_blink_scheduler_if #(
   parameter int N_REQ   = 4,
   parameter int BLINK_W = 4
);
   logic [N_REQ-1:0]         i_req;
   logic [N_REQ*BLINK_W-1:0] i_blinks;
   logic [N_REQ-1:0]         o_ack;
   logic [N_REQ-1:0]         o_done;
   logic                     o_led;
   logic                     o_busy;
   logic [1:0]               o_owner;
   logic [1:0]               state_dbg;

   modport master (
      output i_req, i_blinks,
      input  o_ack, o_done, o_led, o_busy, o_owner, state_dbg
   );

   modport slave (
      input  i_req, i_blinks,
      output o_ack, o_done, o_led, o_busy, o_owner, state_dbg
   );
endinterface

// File: rtl/led_blink_scheduler.sv
// Shares one status LED between up to four requesters. A round-robin
// arbiter grants one burst at a time; a tick-counting FSM then drives
// N timed ON/OFF blinks followed by a guard gap. All outputs registered.
module led_blink_scheduler #(
   parameter int N_REQ     = 4,
   parameter int CNT_W     = 16,
   parameter int BLINK_W   = 4,
   parameter int ON_TICKS  = 25000,
   parameter int OFF_TICKS = 25000,
   parameter int GAP_TICKS = 50000
) (
   input logic                  i_clock,
   input logic                  i_reset_n,
   led_blink_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // Counters load value-1 and count down to 0, so a phase lasts exactly value cycles.
   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_TICKS - 1);
   localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_TICKS - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   tick_q, tick_d;
   logic [BLINK_W-1:0] rem_q, rem_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [1:0]         owner_q, owner_d;
   logic               led_q, led_d;
   logic               busy_q, busy_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [N_REQ-1:0]   done_q, done_d;

   logic               found;
   logic [1:0]         win;
   logic [2:0]         arb_idx;
   logic [BLINK_W-1:0] win_blinks;

   // Round-robin search: first set request starting at ptr_q, wrapping modulo N_REQ.
   always_comb begin
      found   = 1'b0;
      win     = 2'd0;
      arb_idx = 3'd0;
      for (int k = 0; k < N_REQ; k++) begin
         arb_idx = {1'b0, ptr_q} + 3'(k);
         if (arb_idx >= 3'(N_REQ)) begin
            arb_idx = arb_idx - 3'(N_REQ);
         end
         if (!found && bus.i_req[arb_idx[1:0]]) begin
            found = 1'b1;
            win   = arb_idx[1:0];
         end
      end
      win_blinks = bus.i_blinks[int'(win)*BLINK_W +: BLINK_W];
   end

   // Next-state and next-output logic; ack/done are single-cycle pulses.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      rem_d   = rem_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      led_d   = led_q;
      ack_d   = '0;
      done_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               ack_d[win] = 1'b1;
               owner_d    = win;
               ptr_d      = (win == 2'(N_REQ - 1)) ? 2'd0 : win + 2'd1;
               rem_d      = win_blinks;
               if (win_blinks != '0) begin
                  state_d = ST_ON;
                  led_d   = 1'b1;
                  tick_d  = ON_LOAD;
               end else begin
                  // Empty burst: report completion alongside the grant, then guard gap.
                  done_d[win] = 1'b1;
                  state_d     = ST_GAP;
                  led_d       = 1'b0;
                  tick_d      = GAP_LOAD;
               end
            end
         end
         ST_ON: begin
            if (tick_q == '0) begin
               state_d = ST_OFF;
               led_d   = 1'b0;
               tick_d  = OFF_LOAD;
            end else begin
               tick_d = tick_q - CNT_W'(1);
            end
         end
         ST_OFF: begin
            if (tick_q == '0) begin
               rem_d = rem_q - BLINK_W'(1);
               if (rem_q > BLINK_W'(1)) begin
                  state_d = ST_ON;
                  led_d   = 1'b1;
                  tick_d  = ON_LOAD;
               end else begin
                  state_d         = ST_GAP;
                  tick_d          = GAP_LOAD;
                  done_d[owner_q] = 1'b1;
               end
            end else begin
               tick_d = tick_q - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (tick_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               tick_d = tick_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            led_d   = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered-output flops; reset abandons any burst without a done pulse.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         rem_q   <= '0;
         ptr_q   <= 2'd0;
         owner_q <= 2'd0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= '0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         rem_q   <= rem_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   assign bus.o_ack     = ack_q;
   assign bus.o_done    = done_q;
   assign bus.o_led     = led_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_owner   = owner_q;
   assign bus.state_dbg = state_q;

endmodule
